// File: rtl/div_unit_if.sv
// Divide request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(parameter int DATA_W = 32);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held until the initiator drops start.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t          state, state_n;
    logic [5:0]      cnt, cnt_n;
    logic [2*W:0]    dividend, dividend_n;
    logic [W-1:0]    divisor, divisor_n;
    logic            neg1, neg1_n, neg2, neg2_n;
    logic            ready, ready_n;
    logic [2*W-1:0]  result, result_n;

    logic [W-1:0]    abs1, abs2, quo, rem, quo_fix, rem_fix;
    logic [W:0]      diff;
    logic            accept, done;

    assign accept = bus.start_i && !bus.annul_i;
    assign done   = (cnt == 6'(W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FREE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FREE:   if (accept) state_n = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
            S_BYZERO: state_n = bus.annul_i ? S_FREE : S_END;
            S_ON: begin
                if (bus.annul_i)  state_n = S_FREE;
                else if (done)    state_n = S_END;
            end
            S_END:    if (bus.annul_i || !bus.start_i) state_n = S_FREE;
            default:  state_n = S_FREE;
        endcase
    end

    // Magnitudes feed the unsigned core; the sign flags restore signs at the end.
    always_comb begin
        abs1    = (bus.signed_div_i && bus.opdata1_i[W-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs2    = (bus.signed_div_i && bus.opdata2_i[W-1]) ? -bus.opdata2_i : bus.opdata2_i;
        diff    = dividend[2*W:W] - {1'b0, divisor};
        quo     = dividend[W-1:0];
        rem     = dividend[2*W:W+1];
        quo_fix = (neg1 ^ neg2) ? -quo : quo;
        rem_fix = neg1 ? -rem : rem;
    end

    always_comb begin
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        neg1_n     = neg1;
        neg2_n     = neg2;
        ready_n    = ready;
        result_n   = result;
        case (state)
            S_FREE: begin
                ready_n  = 1'b0;
                result_n = '0;
                if (accept) begin
                    neg1_n     = bus.signed_div_i && bus.opdata1_i[W-1];
                    neg2_n     = bus.signed_div_i && bus.opdata2_i[W-1];
                    divisor_n  = abs2;
                    dividend_n = {{W{1'b0}}, abs1, 1'b0};
                    cnt_n      = '0;
                end
            end
            S_BYZERO: begin
                result_n = '0;
                ready_n  = !bus.annul_i;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    cnt_n    = '0;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else if (done) begin
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                end else begin
                    if (diff[W]) dividend_n = {dividend[2*W-1:0], 1'b0};
                    else         dividend_n = {diff[W-1:0], dividend[W-1:0], 1'b1};
                    cnt_n = cnt + 6'd1;
                end
            end
            S_END: begin
                if (bus.annul_i || !bus.start_i) begin
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: begin
                ready_n  = 1'b0;
                result_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            ready    <= 1'b0;
            result   <= '0;
        end else begin
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            neg1     <= neg1_n;
            neg2     <= neg2_n;
            ready    <= ready_n;
            result   <= result_n;
        end
    end

    assign bus.ready_o  = ready;
    assign bus.result_o = result;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle divider serving the execute stage for DIV/DIVU. The execute stage is the initiator; this block is the responder.
- The execute stage raises a start request with operands, stalls until ready is returned, then writes the result into HI/LO.
- HI receives the remainder and LO receives the quotient.
- Iterative restoring division: one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width. result_o is 2*DATA_W wide.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1_i  in  DATA_W  dividend; sampled at accept.
- opdata2_i  in  DATA_W  divisor; sampled at accept.
- start_i  in  1  request; held high by the initiator until it sees ready_o.
- annul_i  in  1  cancel (branch/flush); aborts any in-flight divide.
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1, otherwise 0.
- ready_o  out  1  result valid.

Behaviour:
- Reset: state=FREE, cnt=0, ready_o=0, result_o=0. Applies immediately, including mid-divide.
- States: FREE, BYZERO, ON, END. cnt is 6 bits. The working register dividend is 2*DATA_W+1 bits.
- FREE:
  - If start_i=1 and annul_i=0: capture signed_div_i and the operands.
  - Under signed mode, negative operands are replaced by their two's complement (absolute value).
  - If opdata2_i==0 -> BYZERO. Else dividend={0, |op1|, 1'b0}, divisor=|op2|, cnt=0, -> ON.
  - Otherwise stay in FREE with ready_o=0.
- BYZERO:
  - Next edge -> END with result_o=0 (quotient 0, remainder 0).
  - annul_i=1 -> FREE instead.
- ON, while cnt<DATA_W, each edge:
  - diff = dividend[2W:W] - {1'b0, divisor}.
  - If diff is negative: dividend = dividend<<1.
  - Else: dividend = {diff[W-1:0], dividend[W-1:0], 1'b1}.
  - cnt++.
- ON, when cnt==DATA_W:
  - quotient = dividend[W-1:0]; remainder = dividend[2W:W+1].
  - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. This gives truncation toward zero and a remainder carrying the dividend's sign.
  - Register result_o={rem, quo}, set ready_o=1, -> END.
- ON with annul_i=1 on any edge -> FREE, ready_o=0, result_o=0, cnt=0. The partial result is discarded.
- END:
  - ready_o=1 and result_o are held while start_i=1.
  - When start_i=0 -> FREE, ready_o=0, result_o=0.
  - annul_i=1 also -> FREE.
- Latency: counting the accepting edge as edge 1, ready_o rises after edge 34 (nonzero divisor) or after edge 2 (zero divisor).
- Operand inputs are ignored after accept; changing them in ON does not affect the result.
- start_i and annul_i both high in FREE: not accepted.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0. No exception is raised.
- A new request is accepted only in FREE, so back-to-back divides need start_i low for at least one cycle in END.

Test Plan:
- Unsigned:
  - Stimulus: op1=0xFFFFFFFF, op2=0x00000010, signed=0, start held.
  - Response: ready_o rises after edge 34; result_o=0x0000000F_0FFFFFFF.
- Signed, negative dividend:
  - Stimulus: op1=0xFFFFFFF9 (-7), op2=2.
  - Response: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed, negative divisor:
  - Stimulus: op1=7, op2=-2.
  - Response: quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed, overflow case:
  - Stimulus: 0x80000000 / 0xFFFFFFFF.
  - Response: result_o=0x00000000_80000000.
- Divide by zero:
  - Stimulus: op2=0.
  - Response: ready_o=1 after edge 2 with result_o=0; drop start_i -> ready_o=0 on the next edge.
- Annul and reset:
  - Annul: pulse annul_i at edge 10 of a divide -> FREE, ready_o never asserts. A fresh 100/7 request then gives rem 2, quo 14.
  - Reset: assert rst mid-ON -> ready_o=0 and result_o=0 immediately, without waiting for a clock edge.
